// File: rtl/i2c_eeprom_slave.sv
// rtl/i2c_eeprom_slave.sv - I2C slave fronting a 256x8 memory with sequential read/write
module i2c_eeprom_slave #(
  parameter int          CLK_FRQ  = 50000000,
  parameter logic [6:0]  DEV_ADDR = 7'b1010000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       wr_pulse,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE,
    DEV_BYTE,
    ACK_DEV,
    WORD_BYTE,
    ACK_WORD,
    WDATA_BYTE,
    ACK_WDATA,
    RDATA_BYTE,
    MACK
  } state_e;

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       wr_pulse_q, wr_pulse_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       mem_we;

  logic [7:0] mem [256];

  logic       scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] rx_byte, rd_byte;

  // Two-flop synchronizers plus a history flop for edge detection on both bus lines
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= SCL;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= SDA;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise = scl_s2_q & ~scl_h_q;
  assign scl_fall = ~scl_s2_q & scl_h_q;
  assign start_ev = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_ev  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

  // Byte as it will look once the bit now on the bus is shifted in
  assign rx_byte = {shift_q, sda_s2_q};
  assign rd_byte = mem[ptr_q];

  // Memory write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_q] <= rx_byte;
    end
  end

  // Protocol state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      ptr_q      <= 8'd0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Next-state logic: STOP beats START, which beats SCL edge handling
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;

    if (stop_ev) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_ev) begin
      state_d   = DEV_BYTE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end
        DEV_BYTE: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_d = ACK_DEV;
                busy_d  = 1'b1;
                rw_d    = rx_byte[0];
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end
        ACK_DEV, ACK_WORD, ACK_WDATA: begin
          // First fall (end of bit 8) starts the ACK, second fall (end of bit 9) ends it
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 3'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == ACK_DEV && rw_q) begin
                state_d  = RDATA_BYTE;
                shift_d  = rd_byte[6:0];
                sda_oe_d = ~rd_byte[7];
              end else if (state_q == ACK_DEV) begin
                state_d = WORD_BYTE;
              end else begin
                state_d = WDATA_BYTE;
              end
            end
          end
        end
        WORD_BYTE: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_d   = rx_byte;
              state_d = ACK_WORD;
            end
          end
        end
        WDATA_BYTE: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              mem_we     = 1'b1;
              wr_pulse_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = rx_byte;
              ptr_d      = ptr_q + 8'd1;
              state_d    = ACK_WDATA;
            end
          end
        end
        RDATA_BYTE: begin
          // Bit 7 went out on entry; each fall presents the next bit until all 8 are sent
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              ptr_d     = ptr_q + 8'd1;
              state_d   = MACK;
            end else begin
              sda_oe_d  = ~shift_q[6];
              shift_d   = {shift_q[5:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            if (sda_s2_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              bit_cnt_d = 3'd1;
            end
          end else if (scl_fall && bit_cnt_q == 3'd1) begin
            state_d   = RDATA_BYTE;
            bit_cnt_d = 3'd0;
            shift_d   = rd_byte[6:0];
            sda_oe_d  = ~rd_byte[7];
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb/tb_i2c_eeprom_slave.sv - directed I2C master with a transaction-level memory model
module tb_i2c_eeprom_slave;

  localparam logic [6:0] DEV = 7'b1010000;
  localparam int H = 8;
  localparam int PH_IGN  = 0;
  localparam int PH_DEV  = 1;
  localparam int PH_WORD = 2;
  localparam int PH_DATA = 3;
  localparam int PH_READ = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl   = 1'b1;
  logic       m_low = 1'b0;
  wire        sda_w;
  logic       wr_pulse;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  pullup (sda_w);
  assign sda_w = m_low ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  i2c_eeprom_slave #(.CLK_FRQ(50000000), .DEV_ADDR(DEV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SCL      (scl),
    .SDA      (sda_w),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_mem [256];
  logic [7:0]  m_ptr = 8'd0;
  logic        m_busy = 1'b0;
  int          m_phase = PH_IGN;
  logic [15:0] exp_wr [$];
  logic [7:0]  m_last_addr = 8'd0;
  logic [7:0]  m_last_data = 8'd0;
  logic [7:0]  obs_addr [$];
  logic [7:0]  obs_data [$];
  logic [15:0] e_wr;
  logic [7:0]  got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Every cycle: a write strobe must match the next expected commit, otherwise outputs hold
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_pulse) begin
        obs_addr.push_back(wr_addr);
        obs_data.push_back(wr_data);
        if (exp_wr.size() == 0) begin
          chk("unexpected_wr_pulse", 32'd1, 32'd0);
        end else begin
          e_wr = exp_wr.pop_front();
          chk("wr_addr", {24'd0, wr_addr}, {24'd0, e_wr[15:8]});
          chk("wr_data", {24'd0, wr_data}, {24'd0, e_wr[7:0]});
          m_last_addr = e_wr[15:8];
          m_last_data = e_wr[7:0];
        end
      end else begin
        chk("wr_addr_hold", {24'd0, wr_addr}, {24'd0, m_last_addr});
        chk("wr_data_hold", {24'd0, wr_data}, {24'd0, m_last_data});
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic s);
    wait_n(H);
    m_low = ~b;
    wait_n(H);
    scl = 1'b1;
    wait_n(H);
    s = sda_w;
    wait_n(H);
    scl = 1'b0;
  endtask

  task automatic start_c();
    m_low = 1'b0;
    wait_n(H);
    scl = 1'b1;
    wait_n(H);
    m_low = 1'b1;
    wait_n(H);
    scl = 1'b0;
    m_phase = PH_DEV;
  endtask

  task automatic stop_c();
    m_low = 1'b1;
    wait_n(H);
    scl = 1'b1;
    wait_n(H);
    m_low = 1'b0;
    wait_n(H);
    m_phase = PH_IGN;
    m_busy  = 1'b0;
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ack;
    logic s;
    ack = 1'b0;
    case (m_phase)
      PH_DEV: begin
        if (b[7:1] == DEV) begin
          ack     = 1'b1;
          m_busy  = 1'b1;
          m_phase = b[0] ? PH_READ : PH_WORD;
        end else begin
          m_busy  = 1'b0;
          m_phase = PH_IGN;
        end
      end
      PH_WORD: begin
        ack     = 1'b1;
        m_ptr   = b;
        m_phase = PH_DATA;
      end
      PH_DATA: begin
        ack = 1'b1;
        m_mem[m_ptr] = b;
        exp_wr.push_back({m_ptr, b});
        m_ptr = m_ptr + 8'd1;
      end
      default: ack = 1'b0;
    endcase
    for (int i = 7; i >= 0; i--) begin
      bit_x(b[i], s);
      chk("line_echo", {31'd0, s}, {31'd0, b[i]});
    end
    bit_x(1'b1, s);
    chk("ack_bit", {31'd0, s}, ack ? 32'd0 : 32'd1);
    wait_n(2);
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] r);
    logic [7:0] req;
    logic s;
    req = m_mem[m_ptr];
    m_ptr = m_ptr + 8'd1;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      r[i] = s;
    end
    bit_x(~ack, s);
    chk("master_ack_line", {31'd0, s}, ack ? 32'd0 : 32'd1);
    if (!ack) begin
      m_busy  = 1'b0;
      m_phase = PH_IGN;
    end
    chk("read_byte", {24'd0, r}, {24'd0, req});
    wait_n(2);
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
  endtask

  initial begin
    logic s;
    logic [7:0] dev_w;
    dev_w = 8'hA0;

    // Reset state
    wait_n(4);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
    chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_sda", {31'd0, sda_w}, 32'd1);
    rst_n = 1'b1;
    wait_n(4);

    // Byte write
    start_c();
    send_byte(8'hA0);
    send_byte(8'h1E);
    send_byte(8'h05);
    stop_c();
    chk("bw_pulses", obs_addr.size(), 32'd1);
    if (obs_addr.size() >= 1) begin
      chk("bw_addr_lit", {24'd0, obs_addr[0]}, 32'h1E);
      chk("bw_data_lit", {24'd0, obs_data[0]}, 32'h05);
    end

    // Random read with repeated START
    start_c();
    send_byte(8'hA0);
    send_byte(8'h1E);
    start_c();
    send_byte(8'hA1);
    read_byte(1'b0, got);
    chk("rr_lit", {24'd0, got}, 32'h05);
    stop_c();

    // Wrong device address, later bytes ignored
    start_c();
    send_byte(8'hA2);
    send_byte(8'h33);
    send_byte(8'h44);
    stop_c();

    // Sequential write across the pointer wrap, then current-address read
    start_c();
    send_byte(8'hA0);
    send_byte(8'hFF);
    send_byte(8'h11);
    send_byte(8'h22);
    stop_c();
    chk("wrap_pulses", obs_addr.size(), 32'd3);
    if (obs_addr.size() >= 3) begin
      chk("wrap_addr0_lit", {24'd0, obs_addr[1]}, 32'hFF);
      chk("wrap_addr1_lit", {24'd0, obs_addr[2]}, 32'h00);
    end
    start_c();
    send_byte(8'hA0);
    send_byte(8'hFF);
    stop_c();
    start_c();
    send_byte(8'hA1);
    read_byte(1'b1, got);
    chk("wrap_rd0_lit", {24'd0, got}, 32'h11);
    read_byte(1'b0, got);
    chk("wrap_rd1_lit", {24'd0, got}, 32'h22);
    stop_c();

    // STOP after four data bits must not commit anything
    start_c();
    send_byte(8'hA0);
    send_byte(8'h40);
    for (int i = 0; i < 4; i++) begin
      bit_x(1'b1, s);
    end
    stop_c();

    // Reset while the slave is driving the address ACK
    start_c();
    for (int i = 7; i >= 0; i--) begin
      bit_x(dev_w[i], s);
    end
    m_low = 1'b0;
    wait_n(H);
    chk("ack_driven", {31'd0, sda_w}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_sda_released", {31'd0, sda_w}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    m_busy      = 1'b0;
    m_ptr       = 8'd0;
    m_last_addr = 8'd0;
    m_last_data = 8'd0;
    m_phase     = PH_IGN;
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(H - 1);
    scl = 1'b1;
    wait_n(H);
    chk("ignored_9th", {31'd0, sda_w}, 32'd1);
    wait_n(H);
    scl = 1'b0;
    stop_c();

    // Pointer restarts at zero after reset; memory keeps its contents
    start_c();
    send_byte(8'hA1);
    read_byte(1'b0, got);
    chk("post_reset_rd_lit", {24'd0, got}, 32'h22);
    stop_c();

    wait_n(4);
    chk("exp_wr_drained", exp_wr.size(), 32'd0);
    chk("total_pulses", obs_addr.size(), 32'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
I2C_EEPROM_SLAVE -- requirements
Module: i2c_eeprom_slave

Interface
REQ-001 Parameter CLK_FRQ, default 50000000, system clock frequency in Hz; informational only, no logic depends on it.
REQ-002 Parameter DEV_ADDR, default 7'b1010000, 7-bit I2C device address the block responds to.
REQ-003 Port clk, input, 1, system clock, 50 MHz.
REQ-004 Port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 Port SCL, input, 1, I2C clock from the bus master.
REQ-006 Port SDA, inout, 1, I2C data line. The block SHALL drive only 0 and otherwise present high-Z (open-drain).
REQ-007 Port wr_pulse, output, 1, single-cycle strobe when a data byte is committed to memory.
REQ-008 Port wr_addr, output, 8, memory address of the last committed byte.
REQ-009 Port wr_data, output, 8, value of the last committed byte.
REQ-010 Port busy, output, 1, high from a START addressed to DEV_ADDR until the following STOP or NACK-terminated read.

Function
REQ-011 SCL and SDA SHALL each pass through a 2-flop synchronizer plus one history flop; all bus events are derived from the synchronized signals.
REQ-012 Bus event detection SHALL use these definitions:
- START: sync SDA 1->0 while sync SCL=1.
- STOP: sync SDA 0->1 while sync SCL=1.
- rise/fall: sync SCL 0->1 / 1->0.
REQ-013 Memory SHALL be 256x8, inferred RAM, with one 8-bit address pointer.
REQ-014 Data bits SHALL be sampled MSB-first on SCL rise. SDA SHALL change only on the clk cycle following an SCL fall event.
REQ-015 FSM states SHALL be IDLE, DEV_BYTE, ACK_DEV, WORD_BYTE, ACK_WORD, WDATA_BYTE, ACK_WDATA, RDATA_BYTE and MACK. The state SHALL be held in one register.
REQ-016 START in any state SHALL go to DEV_BYTE with the bit count cleared; this covers repeated START.
REQ-017 STOP in any state SHALL go to IDLE, release SDA, and clear busy.
REQ-018 DEV_BYTE: after 8 bits, if bits[7:1]==DEV_ADDR the block SHALL enter ACK_DEV. Otherwise it SHALL return to IDLE without ACK and with SDA released.
REQ-019 ACK_DEV, ACK_WORD and ACK_WDATA: the block SHALL drive SDA low from the 8th SCL fall to the 9th SCL fall, then release SDA.
REQ-020 After ACK_DEV: R/W=0 SHALL go to WORD_BYTE. R/W=1 SHALL go to RDATA_BYTE, starting from the current pointer.
REQ-021 WORD_BYTE: the received byte SHALL load the pointer, then go to ACK_WORD, then WDATA_BYTE.
REQ-022 WDATA_BYTE: on the 8th bit the block SHALL write mem[ptr], pulse wr_pulse for one clk, update wr_addr/wr_data, and increment ptr mod 256 (0xFF -> 0x00). It SHALL then go to ACK_WDATA, then WDATA_BYTE again (sequential write).
REQ-023 RDATA_BYTE: the block SHALL load mem[ptr] at state entry. After each SCL fall it SHALL drive SDA low for a 0 bit and release it for a 1 bit. After the 8th bit fall it SHALL release SDA, increment ptr mod 256, and go to MACK.
REQ-024 MACK: the block SHALL sample SDA on SCL rise. 0 (ACK) SHALL go to RDATA_BYTE with the next byte. 1 (NACK) SHALL go to IDLE and clear busy.
REQ-025 A STOP or START that arrives mid-byte in WDATA_BYTE SHALL abort the partial byte with no memory write and no wr_pulse.
REQ-026 A write and a STOP detected on the same clk cannot occur, because the commit happens on the SCL rise of bit 8. STOP priority over data events within one clk SHALL nonetheless be STOP > START > rise/fall.
REQ-027 Response latency SHALL be at most 4 clk from the raw SCL edge to the SDA change, which is well inside the 1500 ns SCL low time.

Reset
REQ-028 With rst_n=0 at a clk edge, the block SHALL set: state IDLE, SDA released, busy=0, wr_pulse=0, wr_addr=0, wr_data=0, ptr=0, bit count=0, synchronizers=1. Memory contents are not reset.
REQ-029 Reset asserted mid-transfer SHALL release SDA on the next clk edge. After release, the block SHALL ignore the bus until the next START.

Verification
REQ-030 Byte write: START, 0xA0, 0x1E, 0x05, STOP. Required response: ACK on all three 9th clocks, one wr_pulse with wr_addr=0x1E and wr_data=0x05, busy low after STOP.
REQ-031 Random read: START, 0xA0, 0x1E, repeated START, 0xA1, read one byte, master NACK, STOP. Required response: SDA byte = 0x05, block in IDLE.
REQ-032 Wrong address: START, 0xA2. Required response: SDA high-Z on the 9th clock, no wr_pulse, busy stays 0, remaining bytes ignored.
REQ-033 Wrap: sequential write of 0x11 and 0x22 starting at 0xFF, then current-address read from 0xFF. Required response: wr_addr 0xFF then 0x00; the two reads return 0x11 then 0x22 with master ACK then NACK.
REQ-034 Abort and reset: STOP after 4 data bits gives no wr_pulse. rst_n=0 while the block is driving ACK releases SDA within 1 clk and gives busy=0.
